// File: rtl/multiplier_arbiter_if.sv
// Bundle between two requesters, the arbiter and one shared multiplier.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface multiplier_arbiter_if #(
    parameter int WIDTH = 64
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH-1:0]     req0_multiplier;
    logic [WIDTH-1:0]     req0_multiplicand;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req1_multiplier;
    logic [WIDTH-1:0]     req1_multiplicand;

    logic                 resp0_valid;
    logic                 resp0_ready;
    logic [2*WIDTH-1:0]   resp0_product;
    logic                 resp1_valid;
    logic                 resp1_ready;
    logic [2*WIDTH-1:0]   resp1_product;

    logic                 mult_start;
    logic [WIDTH-1:0]     mult_multiplier;
    logic [WIDTH-1:0]     mult_multiplicand;
    logic [2*WIDTH-1:0]   mult_product;
    logic                 mult_done;

    logic                 busy;
    logic                 latency_err;
    logic                 timeout_err;

    modport slave (
        input  req0_valid, req0_multiplier, req0_multiplicand,
        input  req1_valid, req1_multiplier, req1_multiplicand,
        input  resp0_ready, resp1_ready,
        input  mult_product, mult_done,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_product, resp1_valid, resp1_product,
        output mult_start, mult_multiplier, mult_multiplicand,
        output busy, latency_err, timeout_err
    );

    modport master (
        output req0_valid, req0_multiplier, req0_multiplicand,
        output req1_valid, req1_multiplier, req1_multiplicand,
        output resp0_ready, resp1_ready,
        output mult_product, mult_done,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_product, resp1_valid, resp1_product,
        input  mult_start, mult_multiplier, mult_multiplicand,
        input  busy, latency_err, timeout_err
    );
endinterface

// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiplier between two requesters,
// with latency checking and a WAIT timeout that returns a zero product.
module multiplier_arbiter #(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    multiplier_arbiter_if.slave bus
);
    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(LATENCY);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESPOND} arbState;

    arbState            state;
    arbState            nextState;
    logic               anyValid;
    logic               grantId;
    logic               owner;
    logic               rrPtr;
    logic               respDone;
    logic               doneEdge;
    logic               timeoutEdge;
    logic [WIDTH-1:0]   opMultiplier;
    logic [WIDTH-1:0]   opMultiplicand;
    logic [2*WIDTH-1:0] product;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   countNext;
    logic               latencyErr;
    logic               timeoutErr;

    assign anyValid = bus.req0_valid | bus.req1_valid;
    // The pointer only matters on contention; a lone requester always wins.
    assign grantId  = (bus.req0_valid & bus.req1_valid) ? rrPtr : bus.req1_valid;

    // countNext is the number of edges since mult_start at the edge now closing.
    assign countNext   = (count == CNT_MAX) ? count : count + 1'b1;
    assign doneEdge    = (state == WAIT) && bus.mult_done;
    assign timeoutEdge = (state == WAIT) && !bus.mult_done && (countNext == CNT_MAX);
    assign respDone    = (state == RESPOND) && (owner ? bus.resp1_ready : bus.resp0_ready);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // NOTE: every combinational output gets a default first, so no path through
    // the case statement can leave a value held and infer a latch.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (anyValid) nextState = LAUNCH;
            LAUNCH:  nextState = WAIT;
            WAIT:    if (doneEdge || timeoutEdge) nextState = RESPOND;
            RESPOND: if (respDone) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner          <= 1'b0;
            rrPtr          <= 1'b0;
            opMultiplier   <= '0;
            opMultiplicand <= '0;
            product        <= '0;
            count          <= '0;
            latencyErr     <= 1'b0;
            timeoutErr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyValid) begin
                        owner          <= grantId;
                        opMultiplier   <= grantId ? bus.req1_multiplier   : bus.req0_multiplier;
                        opMultiplicand <= grantId ? bus.req1_multiplicand : bus.req0_multiplicand;
                    end
                end
                LAUNCH: count <= '0;
                WAIT: begin
                    count <= countNext;
                    if (doneEdge) begin
                        product <= bus.mult_product;
                        if (countNext != CNT_LAT) latencyErr <= 1'b1;
                    end else if (timeoutEdge) begin
                        product    <= '0;
                        timeoutErr <= 1'b1;
                    end
                end
                RESPOND: if (respDone) rrPtr <= ~owner;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.req0_ready        = 1'b0;
        bus.req1_ready        = 1'b0;
        bus.resp0_valid       = 1'b0;
        bus.resp1_valid       = 1'b0;
        bus.resp0_product     = '0;
        bus.resp1_product     = '0;
        bus.mult_start        = 1'b0;
        bus.mult_multiplier   = '0;
        bus.mult_multiplicand = '0;
        case (state)
            IDLE: begin
                // Gated by rst so nothing is offered while reset is held.
                bus.req0_ready = rst & anyValid & ~grantId;
                bus.req1_ready = rst & anyValid &  grantId;
            end
            LAUNCH: begin
                bus.mult_start        = 1'b1;
                bus.mult_multiplier   = opMultiplier;
                bus.mult_multiplicand = opMultiplicand;
            end
            WAIT: begin
                bus.mult_multiplier   = opMultiplier;
                bus.mult_multiplicand = opMultiplicand;
            end
            RESPOND: begin
                bus.resp0_valid   = ~owner;
                bus.resp1_valid   =  owner;
                bus.resp0_product = owner ? '0 : product;
                bus.resp1_product = owner ? product : '0;
            end
            default: ;
        endcase
        bus.busy        = (state != IDLE);
        bus.latency_err = latencyErr;
        bus.timeout_err = timeoutErr;
    end
endmodule

// File: tb/tb_multiplier_arbiter.sv
// Randomized bench for multiplier_arbiter: a behavioural multiplier model plus
// expected grants, products, timing and sticky flags derived from the operation rules.
module tb_multiplier_arbiter;
    localparam int WIDTH   = 64;
    localparam int LATENCY = 12;
    localparam int TIMEOUT = 40;

    typedef logic [2*WIDTH-1:0] prodT;
    typedef logic [WIDTH-1:0]   opT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multiplier_arbiter_if #(.WIDTH(WIDTH)) bus ();

    multiplier_arbiter #(
        .WIDTH  (WIDTH),
        .LATENCY(LATENCY),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int nChecks   = 0;
    int nErrors   = 0;
    int doneDelay = LATENCY;   // edges after mult_start that the model answers; <=0 never
    bit expLatErr = 1'b0;
    bit expToErr  = 1'b0;
    bit expPtr    = 1'b0;

    task automatic check(input string tag, input prodT got, input prodT exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic reqReady(input int id);
        return (id != 0) ? bus.req1_ready : bus.req0_ready;
    endfunction

    function automatic logic respValid(input int id);
        return (id != 0) ? bus.resp1_valid : bus.resp0_valid;
    endfunction

    function automatic prodT respProd(input int id);
        return (id != 0) ? bus.resp1_product : bus.resp0_product;
    endfunction

    task automatic driveReq(input int id, input logic v, input opT a, input opT b);
        if (id != 0) begin
            bus.req1_valid = v; bus.req1_multiplier = a; bus.req1_multiplicand = b;
        end else begin
            bus.req0_valid = v; bus.req0_multiplier = a; bus.req0_multiplicand = b;
        end
    endtask

    task automatic setRespReady(input int id, input logic v);
        if (id != 0) bus.resp1_ready = v;
        else         bus.resp0_ready = v;
    endtask

    // Shared multiplier model: answers doneDelay edges after the edge that samples mult_start.
    initial begin
        opT a;
        opT b;
        int d;
        bus.mult_done    = 1'b0;
        bus.mult_product = '0;
        forever begin
            @(negedge clk);
            if (bus.mult_start === 1'b1) begin
                a = bus.mult_multiplier;
                b = bus.mult_multiplicand;
                d = doneDelay;
                @(posedge clk);
                if (d > 0) begin
                    repeat (d - 1) @(posedge clk);
                    #1;
                    bus.mult_done    = 1'b1;
                    bus.mult_product = prodT'(a) * prodT'(b);
                    @(posedge clk);
                    #1;
                    bus.mult_done    = 1'b0;
                    bus.mult_product = '0;
                end
            end
        end
    end

    // One uncontended operation from request to response handshake.
    task automatic runOp(input int id, input opT a, input opT b, input int delay, input int stall);
        prodT expProd;
        int   edges;
        int   expEdges;
        bit   opsStable;
        doneDelay = delay;
        expProd   = (delay > 0) ? prodT'(a) * prodT'(b) : '0;
        expEdges  = (delay > 0) ? delay + 1 : TIMEOUT + 1;
        @(posedge clk); #1;
        driveReq(id, 1'b1, a, b);
        @(negedge clk);
        check("req_ready", prodT'(reqReady(id)), prodT'(1));
        check("other_ready", prodT'(reqReady(1 - id)), prodT'(0));
        @(posedge clk); #1;
        driveReq(id, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
        @(negedge clk);
        check("mult_start", prodT'(bus.mult_start), prodT'(1));
        check("launch_ops", {bus.mult_multiplier, bus.mult_multiplicand}, {a, b});
        edges     = 0;
        opsStable = 1'b1;
        while (!respValid(id) && edges < TIMEOUT + 8) begin
            @(negedge clk);
            edges++;
            if (!respValid(id))
                opsStable &= (bus.mult_multiplier == a) && (bus.mult_multiplicand == b) && !bus.mult_start;
        end
        check("ops_hold", prodT'(opsStable), prodT'(1));
        check("resp_valid", prodT'(respValid(id)), prodT'(1));
        check("resp_latency", prodT'(edges), prodT'(expEdges));
        check("resp_product", respProd(id), expProd);
        check("other_valid", prodT'(respValid(1 - id)), prodT'(0));
        check("other_product", respProd(1 - id), prodT'(0));
        repeat (stall) begin
            setRespReady(1 - id, 1'b1);
            @(negedge clk);
            check("stall_valid", prodT'(respValid(id)), prodT'(1));
            check("stall_product", respProd(id), expProd);
        end
        setRespReady(1 - id, 1'b0);
        setRespReady(id, 1'b1);
        @(posedge clk); #1;
        setRespReady(id, 1'b0);
        expPtr     = (id == 0);
        expLatErr |= (delay > 0) && (delay != LATENCY);
        expToErr  |= (delay <= 0);
        @(negedge clk);
        check("idle_busy", prodT'(bus.busy), prodT'(0));
        check("resp_clear", prodT'(respValid(id)), prodT'(0));
        check("latency_err", prodT'(bus.latency_err), prodT'(expLatErr));
        check("timeout_err", prodT'(bus.timeout_err), prodT'(expToErr));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        opT   ones;
        bit   stray;
        int   gid;
        int   n;
        prodT expC;
        rst = 1'b0;
        driveReq(0, 1'b1, '0, '0);
        driveReq(1, 1'b0, '0, '0);
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", prodT'(bus.busy), prodT'(0));
        check("rst_ready0", prodT'(bus.req0_ready), prodT'(0));
        check("rst_mult_start", prodT'(bus.mult_start), prodT'(0));
        check("rst_ops", {bus.mult_multiplier, bus.mult_multiplicand}, prodT'(0));
        check("rst_resp", prodT'({bus.resp0_valid, bus.resp1_valid}), prodT'(0));
        check("rst_flags", prodT'({bus.latency_err, bus.timeout_err}), prodT'(0));
        driveReq(0, 1'b0, '0, '0);
        @(posedge clk); #1;
        rst = 1'b1;

        runOp(0, opT'(3), opT'(5), LATENCY, 0);
        ones = '1;
        runOp(1, ones, ones, LATENCY, 2);
        for (int i = 0; i < 6; i++)
            runOp(int'($urandom_range(1, 0)), {$urandom, $urandom}, {$urandom, $urandom},
                  LATENCY, int'($urandom_range(3, 0)));

        runOp(0, {$urandom, $urandom}, {$urandom, $urandom}, LATENCY - 1, 0);
        runOp(1, {$urandom, $urandom}, {$urandom, $urandom}, LATENCY, 1);
        for (int i = 0; i < 4; i++)
            runOp(int'($urandom_range(1, 0)), {$urandom, $urandom}, {$urandom, $urandom},
                  int'($urandom_range(TIMEOUT - 1, 1)), 0);

        runOp(1, {$urandom, $urandom}, {$urandom, $urandom}, -1, 0);
        runOp(1, {$urandom, $urandom}, {$urandom, $urandom}, LATENCY, 10);

        // Reset in the middle of WAIT, with the model's completion arriving afterwards.
        doneDelay = LATENCY;
        @(posedge clk); #1;
        driveReq(0, 1'b1, opT'(11), opT'(13));
        @(posedge clk); #1;
        driveReq(0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        bus.req1_valid = 1'b1;
        #1;
        check("midrst_busy", prodT'(bus.busy), prodT'(0));
        check("midrst_start_ready", prodT'({bus.mult_start, bus.req0_ready, bus.req1_ready}), prodT'(0));
        check("midrst_ops", {bus.mult_multiplier, bus.mult_multiplicand}, prodT'(0));
        check("midrst_resp", prodT'({bus.resp0_valid, bus.resp1_valid}), prodT'(0));
        check("midrst_flags", prodT'({bus.latency_err, bus.timeout_err}), prodT'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req1_valid = 1'b0;
        expLatErr = 1'b0;
        expToErr  = 1'b0;
        expPtr    = 1'b0;
        stray = 1'b0;
        repeat (LATENCY + 4) begin
            @(negedge clk);
            stray |= bus.busy | bus.resp0_valid | bus.resp1_valid | bus.latency_err | bus.timeout_err;
        end
        check("stray_done_ignored", prodT'(stray), prodT'(0));

        // Contention: both requesters hold valid; grants must alternate from requester 0.
        doneDelay = LATENCY;
        @(posedge clk); #1;
        driveReq(0, 1'b1, opT'(2), opT'(2));
        driveReq(1, 1'b1, opT'(7), opT'(9));
        for (int g = 0; g < 3; g++) begin
            gid = -1;
            n   = 0;
            while (gid < 0 && n < 20) begin
                @(negedge clk);
                n++;
                check("ready_onehot", prodT'(bus.req0_ready & bus.req1_ready), prodT'(0));
                if (bus.req0_ready)      gid = 0;
                else if (bus.req1_ready) gid = 1;
            end
            check("rr_grant", prodT'(gid), prodT'(expPtr));
            if (gid >= 0) begin
                @(posedge clk); #1;
                if (g == 2) begin
                    driveReq(0, 1'b0, '0, '0);
                    driveReq(1, 1'b0, '0, '0);
                end
                n = 0;
                while (!respValid(gid) && n < TIMEOUT + 8) begin
                    @(negedge clk);
                    n++;
                    check("no_ready_busy", prodT'(bus.req0_ready | bus.req1_ready), prodT'(0));
                end
                expC = (gid != 0) ? prodT'(63) : prodT'(4);
                check("contend_product", respProd(gid), expC);
                setRespReady(gid, 1'b1);
                @(posedge clk); #1;
                setRespReady(gid, 1'b0);
                expPtr = (gid == 0);
            end
        end
        @(negedge clk);
        check("final_busy", prodT'(bus.busy), prodT'(0));
        check("final_flags", prodT'({bus.latency_err, bus.timeout_err}), prodT'(0));

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end
endmodule

// File: doc/multiplier_arbiter.md
MULTIPLIER_ARBITER -- requirements
Module: multiplier_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand width in bits.
REQ-002 SHALL have parameter LATENCY, default 64, expected clk edges from the edge that samples mult_start=1 to the edge that samples mult_done=1.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before abort; TIMEOUT > LATENCY.
REQ-004 SHALL have ports, one clock, asynchronous active-low reset:
 clk  in  1  rising-edge clock
 rst  in  1  asynchronous reset, active-low
 req0_valid  in  1  requester 0 operands valid
 req0_ready  out  1  requester 0 accept strobe
 req0_multiplier  in  WIDTH  requester 0 multiplier
 req0_multiplicand  in  WIDTH  requester 0 multiplicand
 req1_valid, req1_ready, req1_multiplier, req1_multiplicand  same as requester 0
 resp0_valid  out  1  product valid to requester 0
 resp0_ready  in  1  requester 0 takes product
 resp0_product  out  2*WIDTH  product to requester 0
 resp1_valid, resp1_ready, resp1_product  same as requester 0
 mult_start  out  1  one-cycle launch pulse to shared multiplier
 mult_multiplier  out  WIDTH  operand to multiplier
 mult_multiplicand  out  WIDTH  operand to multiplier
 mult_product  in  2*WIDTH  multiplier result
 mult_done  in  1  multiplier result valid
 busy  out  1  high in any state other than IDLE
 latency_err  out  1  sticky: a completion arrived at count != LATENCY
 timeout_err  out  1  sticky: TIMEOUT reached without mult_done

Function
REQ-005 SHALL implement FSM states IDLE, LAUNCH, WAIT, RESPOND.
REQ-006 IDLE: if any reqN_valid, SHALL grant one requester, pulse its reqN_ready for that cycle (combinational on valid, IDLE, grant), latch its operands and owner ID, go to LAUNCH; else stay.
REQ-007 Both valid in IDLE: SHALL grant the requester indicated by a round-robin pointer; pointer SHALL move to the non-owner when a response completes.
REQ-008 Only one reqN_ready SHALL be high in any cycle; no ready outside IDLE.
REQ-009 LAUNCH: SHALL assert mult_start for exactly one cycle, clear the latency counter, go to WAIT.
REQ-010 mult_multiplier/mult_multiplicand SHALL hold latched operands, stable from LAUNCH through end of WAIT; zero in IDLE.
REQ-011 WAIT: counter SHALL increment each cycle, saturating at TIMEOUT; value at the mult_done edge equals edges since mult_start.
REQ-012 WAIT with mult_done=1: SHALL latch mult_product, set latency_err if count != LATENCY, go to RESPOND.
REQ-013 WAIT with count == TIMEOUT and no mult_done: SHALL set timeout_err, latch product 0, go to RESPOND.
REQ-014 mult_done outside WAIT SHALL be ignored, with no state or flag change.
REQ-015 RESPOND: SHALL assert respN_valid for the owner only, respN_product = latched product, both held stable until respN_ready=1; then go to IDLE; non-owner resp_product SHALL be 0.
REQ-016 respN_ready while respN_valid=0 SHALL be ignored.
REQ-017 Back-to-back: a request valid in IDLE SHALL be accepted that cycle; minimum per-operation occupancy is LATENCY+3 cycles (IDLE, LAUNCH, LATENCY WAIT, RESPOND).
REQ-018 Operand changes on reqN_* after acceptance SHALL NOT affect the operation in flight.
REQ-019 latency_err and timeout_err SHALL stay set until reset.

Reset
REQ-020 rst=0 SHALL asynchronously force IDLE, pointer to requester 0, counter 0, latched operands/product 0, all outputs 0.
REQ-021 Reset mid-operation (LAUNCH/WAIT/RESPOND) SHALL abandon it with no response; a mult_done arriving after reset release SHALL be ignored.
REQ-022 First grant after reset release SHALL follow REQ-006/007 with pointer at requester 0.

Verification
REQ-023 Single request: req0 3 x 5, multiplier model done at LATENCY -> mult_start one cycle after req0_ready, resp0_product=15, latency_err=0.
REQ-024 Contention: both valid continuously, req0 2x2, req1 7x9 -> req0 served first (product 4), then req1 (product 63), then req0 again; never two readys at once.
REQ-025 Latency mismatch: model asserts done at LATENCY-1 -> response delivered, latency_err=1 and stays 1 through later correct operations.
REQ-026 Timeout: model never asserts done -> after TIMEOUT WAIT cycles timeout_err=1, owner gets product 0, FSM back to IDLE.
REQ-027 Backpressure and reset: resp1_ready held 0 for 10 cycles -> resp1_valid/product stable; then rst=0 during next WAIT -> all outputs 0 immediately, stray done ignored, busy=0.
REQ-028 Extremes: WIDTH=64, all-ones x all-ones -> product 0xFFFF...FFFE0000...0001 (2*WIDTH bits) passed through unchanged.
